updi_target_responder: RTL and testbench
========================================

// Module: updi_target_responder
// PURPOSE
//  UPDI target-side (device) protocol responder: the far end of the programmer state machine.
//  - Sits behind the UART/UPDI bridge and consumes received bytes.
//  - Decodes SYNC + LDCS/STCS/KEY instructions, maintains the UPDI CS/ASI register file, and returns LDCS data after a guard time.
//  - Used as an on-FPGA loopback target to bring up and regress the programmer without silicon.
// PARAMETERS
//  GUARD_CYCLES  64     clk cycles from last rx byte to tx_valid for any response (min 1)
//  UPDI_REV      4'h3   value of STATUSA[7:4]
//  SIB_WORD      128'h… 16-byte SIB image, byte 0 = [7:0], sent first (only with UPDI_TGT_SIB_EN)
// PORTS
//  clk            in   1    system clock
//  rst            in   1    synchronous active-high reset
//  rx_valid       in   1    one-cycle strobe: rx_data holds a received byte (own echo already stripped by bridge)
//  rx_data        in   8    received byte
//  rx_break       in   1    one-cycle strobe: BREAK detected on line
//  tx_data        out  8    response byte
//  tx_valid       out  1    response byte valid; held until tx_ready
//  tx_ready       in   1    bridge accepts byte when tx_valid&&tx_ready
//  key_status     out  8    mirror of ASI_KEY_STATUS (CS 0x7)
//  sys_reset_req  out  1    high while ASI_RESET_REQ == 8'h59
//  nvmprog_active out  1    mirror of ASI_SYS_STATUS[3]
//  busy           out  1    state != TGT_IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state TGT_IDLE, CS regs 0 except STATUSA = {UPDI_REV,4'h0}.
//  States:
//  - TGT_IDLE: rx 8'h55 -> TGT_OPCODE; any other byte ignored.
//  - TGT_OPCODE: next rx byte b:
//    - b[7:4]==4'h8 LDCS(addr=b[3:0]) -> TGT_GUARD
//    - b[7:4]==4'hC STCS -> TGT_STCS_DATA
//    - b==8'hE0 KEY 64-bit -> TGT_KEY_DATA, byte count 0
//    - b==8'hE5 SIB -> see CONFIGURATION
//    - anything else: STATUSB[2:0]=3'h4 (illegal opcode) -> TGT_ERROR
//  - TGT_STCS_DATA: next rx byte written to CS[addr] -> TGT_IDLE.
//    - STATUSA(0x0), KEY_STATUS(0x7), SYS_STATUS(0xB) are read-only; writes dropped.
//  - TGT_KEY_DATA: shift 8 bytes, key transmitted last-char-first, then compare:
//    - "NVMProg " sets KEY_STATUS[4]
//    - "NVMErase" sets KEY_STATUS[3]
//    - mismatch: no change
//    - then -> TGT_IDLE
//  - TGT_GUARD: count GUARD_CYCLES from the cycle after the opcode byte -> TGT_RESP.
//    - rx_valid during guard -> STATUSB[2:0]=3'h1 (parity/frame class), -> TGT_ERROR.
//  - TGT_RESP: tx_data=CS[addr], tx_valid=1 until handshake; on handshake -> TGT_IDLE.
//    - Unimplemented CS addresses read 8'h00.
//  - TGT_ERROR: ignore all bytes until rx_break.
//  - rx_break in ANY state (top priority over rx_valid same cycle): drop tx_valid, -> TGT_IDLE.
//    - CS regs and key status are retained.
//  ASI reset sequence:
//  - STCS 0x8 <- 8'h59 asserts sys_reset_req.
//  - STCS 0x8 <- 8'h00 releases it; on release, if KEY_STATUS[4], set SYS_STATUS[3] and clear KEY_STATUS[4].
//  - If KEY_STATUS[3] on release, clear KEY_STATUS[3] and SYS_STATUS[0] (LOCKSTATUS).
//  - SYS_STATUS[0] resets to 1 (locked).
//  Next-opcode latency: TGT_IDLE is re-entered the cycle after the last rx byte or tx handshake.
//  rst mid-response: tx_valid drops next edge; no partial byte is held.
// CONFIGURATION
//  UPDI_TGT_SIB_EN defined:
//  - opcode 8'hE5 -> TGT_GUARD, then 16 bytes of SIB_WORD sent back-to-back under tx handshake.
//  - Only one guard before byte 0 -> TGT_IDLE.
//  UPDI_TGT_SIB_EN undefined:
//  - 8'hE5 treated as illegal opcode (STATUSB=3'h4, TGT_ERROR); no SIB storage synthesised.
// STRUCTURE
//  Package updi_pkg:
//  - updi_target_state enum (TGT_IDLE..TGT_ERROR)
//  - UPDI_SYNC, opcode masks, CS address localparams
//  - 64-bit NVMPROG/CHIPERASE key constants
//  - PESIG codes
//  Sub-module updi_cs_regfile: 16x8 CS/ASI regs, RO masking, ASI reset-release side effects; responder owns the FSM, guard counter and key shifter.
// TESTING
//  - 55,82 -> after GUARD_CYCLES tx 8'h30; tx_ready low 5 cycles holds tx_valid/tx_data stable.
//  - 55,C3,08 then 55,83 -> response 8'h08; 55,C0,FF then 55,80 -> 8'h30 (RO kept).
//  - 55,E0,20 67 6F 72 50 4D 56 4E -> key_status==8'h10; then STCS 8<-59 -> sys_reset_req=1.
//    - Then STCS 8<-00 -> nvmprog_active=1, key_status==0.
//  - 55,A5 -> no tx, STATUSB=4; bytes 55,80 ignored; rx_break then 55,81 -> tx 8'h04.
//  - 55,80 with rx_break during TGT_RESP -> tx_valid low next cycle, busy=0; rst mid-KEY -> all outputs 0.
//  - UPDI_TGT_SIB_EN: 55,E5 -> 16 bytes equal SIB_WORD LSB-first; undefined: STATUSB=4, no tx.

Source files
------------

// File: rtl/updi_pkg.sv
// Shared definitions for the UPDI target responder: FSM states, opcodes, CS map, keys, PESIG codes.
package updi_pkg;

   typedef enum logic [2:0] {
      TGT_IDLE,
      TGT_OPCODE,
      TGT_STCS_DATA,
      TGT_KEY_DATA,
      TGT_GUARD,
      TGT_RESP,
      TGT_ERROR
   } updi_target_state;

   localparam logic [7:0] UPDI_SYNC  = 8'h55;
   localparam logic [3:0] OPC_LDCS   = 4'h8;
   localparam logic [3:0] OPC_STCS   = 4'hC;
   localparam logic [7:0] OPC_KEY64  = 8'hE0;
   localparam logic [7:0] OPC_SIB    = 8'hE5;

   localparam logic [3:0] CS_STATUSA         = 4'h0;
   localparam logic [3:0] CS_STATUSB         = 4'h1;
   localparam logic [3:0] CS_CTRLA           = 4'h2;
   localparam logic [3:0] CS_CTRLB           = 4'h3;
   localparam logic [3:0] CS_ASI_KEY_STATUS  = 4'h7;
   localparam logic [3:0] CS_ASI_RESET_REQ   = 4'h8;
   localparam logic [3:0] CS_ASI_CTRLA       = 4'h9;
   localparam logic [3:0] CS_ASI_SYS_CTRLA   = 4'hA;
   localparam logic [3:0] CS_ASI_SYS_STATUS  = 4'hB;
   localparam logic [3:0] CS_ASI_CRC_STATUS  = 4'hC;

   localparam logic [7:0] ASI_RESET_MAGIC = 8'h59;

   // ASCII with the first character in the top byte; the programmer sends the low byte first.
   localparam logic [63:0] KEY_NVMPROG   = 64'h4E564D50726F6720;
   localparam logic [63:0] KEY_CHIPERASE = 64'h4E564D4572617365;

   localparam logic [2:0] PESIG_NONE       = 3'h0;
   localparam logic [2:0] PESIG_PARITY     = 3'h1;
   localparam logic [2:0] PESIG_ILLEGAL_OP = 3'h4;

   function automatic logic cs_implemented(input logic [3:0] addr);
      case (addr)
         CS_STATUSA, CS_STATUSB, CS_CTRLA, CS_CTRLB, CS_ASI_KEY_STATUS, CS_ASI_RESET_REQ,
         CS_ASI_CTRLA, CS_ASI_SYS_CTRLA, CS_ASI_SYS_STATUS, CS_ASI_CRC_STATUS: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic cs_read_only(input logic [3:0] addr);
      return (addr == CS_STATUSA) || (addr == CS_ASI_KEY_STATUS) || (addr == CS_ASI_SYS_STATUS);
   endfunction

endpackage

// File: rtl/updi_cs_regfile.sv
// UPDI CS/ASI register file: 16x8 registers, read-only masking and ASI reset-release side effects.
module updi_cs_regfile
   import updi_pkg::*;
#(
   parameter logic [3:0] UPDI_REV = 4'h3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [3:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic       err_en,
   input  logic [2:0] err_code,
   input  logic       key_prog_set,
   input  logic       key_erase_set,
   input  logic [3:0] rd_addr,
   output logic [7:0] rd_data,
   output logic [7:0] key_status,
   output logic       sys_reset_req,
   output logic       nvmprog_active
);

   logic [7:0] regs [16];
   logic       wr_ok;
   logic       release_req;

   assign wr_ok       = wr_en && cs_implemented(wr_addr) && !cs_read_only(wr_addr);
   assign release_req = wr_en && (wr_addr == CS_ASI_RESET_REQ) && (wr_data == 8'h00)
                        && (regs[CS_ASI_RESET_REQ] == ASI_RESET_MAGIC);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
         regs[CS_STATUSA]        <= {UPDI_REV, 4'h0};
         regs[CS_ASI_SYS_STATUS] <= 8'h01;
      end else begin
         if (wr_ok) regs[wr_addr] <= wr_data;
         if (err_en) regs[CS_STATUSB][2:0] <= err_code;
         if (key_prog_set) regs[CS_ASI_KEY_STATUS][4] <= 1'b1;
         if (key_erase_set) regs[CS_ASI_KEY_STATUS][3] <= 1'b1;
         // Leaving reset promotes a granted key into its system-level effect.
         if (release_req) begin
            if (regs[CS_ASI_KEY_STATUS][4]) begin
               regs[CS_ASI_SYS_STATUS][3] <= 1'b1;
               regs[CS_ASI_KEY_STATUS][4] <= 1'b0;
            end
            if (regs[CS_ASI_KEY_STATUS][3]) begin
               regs[CS_ASI_KEY_STATUS][3] <= 1'b0;
               regs[CS_ASI_SYS_STATUS][0] <= 1'b0;
            end
         end
      end
   end

   assign rd_data        = cs_implemented(rd_addr) ? regs[rd_addr] : 8'h00;
   assign key_status     = regs[CS_ASI_KEY_STATUS];
   assign sys_reset_req  = (regs[CS_ASI_RESET_REQ] == ASI_RESET_MAGIC);
   assign nvmprog_active = regs[CS_ASI_SYS_STATUS][3];

endmodule

// File: rtl/updi_target_responder.sv
// UPDI target-side protocol responder: SYNC/LDCS/STCS/KEY decode, guard timing and response.
// Optional SIB readout (opcode 0xE5) is built only when UPDI_TGT_SIB_EN is defined.
module updi_target_responder
   import updi_pkg::*;
#(
   parameter int         GUARD_CYCLES = 64,
   parameter logic [3:0] UPDI_REV     = 4'h3
`ifdef UPDI_TGT_SIB_EN
   , parameter logic [127:0] SIB_WORD = 128'h33_2D_31_3A_44_32_3A_50_20_20_20_20_20_52_56_41
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   input  logic       rx_break,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic [7:0] key_status,
   output logic       sys_reset_req,
   output logic       nvmprog_active,
   output logic       busy
);

   localparam int GW = (GUARD_CYCLES < 2) ? 1 : $clog2(GUARD_CYCLES);
   localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES - 1);
   // The opcode cycle itself counts toward the guard, so a 1-cycle guard skips TGT_GUARD.
   localparam updi_target_state GUARD_ENTRY = (GUARD_CYCLES == 1) ? TGT_RESP : TGT_GUARD;

   updi_target_state state_reg, state_next;
   logic [3:0]    addr_reg, addr_next;
   logic [GW-1:0] guard_reg, guard_next;
   logic [63:0]   key_reg, key_next, key_full;
   logic [2:0]    key_cnt_reg, key_cnt_next;
   logic          cs_wr_en, cs_err_en, key_prog_set, key_erase_set;
   logic [2:0]    cs_err_code;
   logic [7:0]    cs_rd_data, resp_byte;

`ifdef UPDI_TGT_SIB_EN
   logic       sib_mode_reg, sib_mode_next;
   logic [3:0] sib_idx_reg, sib_idx_next;
   logic [7:0] sib_bytes [16];

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_sib
         assign sib_bytes[gi] = SIB_WORD[gi*8 +: 8];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         sib_mode_reg <= 1'b0;
         sib_idx_reg  <= 4'h0;
      end else begin
         sib_mode_reg <= sib_mode_next;
         sib_idx_reg  <= sib_idx_next;
      end
   end

   assign resp_byte = sib_mode_reg ? sib_bytes[sib_idx_reg] : cs_rd_data;
`else
   assign resp_byte = cs_rd_data;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= TGT_IDLE;
         addr_reg    <= 4'h0;
         guard_reg   <= '0;
         key_reg     <= 64'h0;
         key_cnt_reg <= 3'h0;
      end else begin
         state_reg   <= state_next;
         addr_reg    <= addr_next;
         guard_reg   <= guard_next;
         key_reg     <= key_next;
         key_cnt_reg <= key_cnt_next;
      end
   end

   // Key bytes arrive last-character-first, so shifting in from the top leaves ASCII order.
   assign key_full = {rx_data, key_reg[63:8]};

   always_comb begin
      state_next    = state_reg;
      addr_next     = addr_reg;
      guard_next    = guard_reg;
      key_next      = key_reg;
      key_cnt_next  = key_cnt_reg;
      cs_wr_en      = 1'b0;
      cs_err_en     = 1'b0;
      cs_err_code   = PESIG_NONE;
      key_prog_set  = 1'b0;
      key_erase_set = 1'b0;
`ifdef UPDI_TGT_SIB_EN
      sib_mode_next = sib_mode_reg;
      sib_idx_next  = sib_idx_reg;
`endif
      if (rx_break) begin
         state_next = TGT_IDLE;
      end else begin
         case (state_reg)
            TGT_IDLE: if (rx_valid && rx_data == UPDI_SYNC) state_next = TGT_OPCODE;
            TGT_OPCODE: if (rx_valid) begin
               addr_next  = rx_data[3:0];
               guard_next = GUARD_LOAD;
`ifdef UPDI_TGT_SIB_EN
               sib_mode_next = 1'b0;
               sib_idx_next  = 4'h0;
`endif
               if (rx_data[7:4] == OPC_LDCS) begin
                  state_next = GUARD_ENTRY;
               end else if (rx_data[7:4] == OPC_STCS) begin
                  state_next = TGT_STCS_DATA;
               end else if (rx_data == OPC_KEY64) begin
                  state_next   = TGT_KEY_DATA;
                  key_cnt_next = 3'h0;
`ifdef UPDI_TGT_SIB_EN
               end else if (rx_data == OPC_SIB) begin
                  state_next    = GUARD_ENTRY;
                  sib_mode_next = 1'b1;
`endif
               end else begin
                  cs_err_en   = 1'b1;
                  cs_err_code = PESIG_ILLEGAL_OP;
                  state_next  = TGT_ERROR;
               end
            end
            TGT_STCS_DATA: if (rx_valid) begin
               cs_wr_en   = 1'b1;
               state_next = TGT_IDLE;
            end
            TGT_KEY_DATA: if (rx_valid) begin
               key_next     = key_full;
               key_cnt_next = key_cnt_reg + 3'd1;
               if (key_cnt_reg == 3'd7) begin
                  key_prog_set  = (key_full == KEY_NVMPROG);
                  key_erase_set = (key_full == KEY_CHIPERASE);
                  state_next    = TGT_IDLE;
               end
            end
            TGT_GUARD: begin
               if (rx_valid) begin
                  cs_err_en   = 1'b1;
                  cs_err_code = PESIG_PARITY;
                  state_next  = TGT_ERROR;
               end else if (guard_reg <= GW'(1)) begin
                  state_next = TGT_RESP;
               end else begin
                  guard_next = guard_reg - GW'(1);
               end
            end
            TGT_RESP: if (tx_ready) begin
`ifdef UPDI_TGT_SIB_EN
               if (sib_mode_reg && sib_idx_reg != 4'hF) sib_idx_next = sib_idx_reg + 4'd1;
               else state_next = TGT_IDLE;
`else
               state_next = TGT_IDLE;
`endif
            end
            TGT_ERROR: state_next = TGT_ERROR;
            default:   state_next = TGT_IDLE;
         endcase
      end
   end

   updi_cs_regfile #(.UPDI_REV(UPDI_REV)) u_regs (
      .clk            (clk),
      .rst            (rst),
      .wr_en          (cs_wr_en),
      .wr_addr        (addr_reg),
      .wr_data        (rx_data),
      .err_en         (cs_err_en),
      .err_code       (cs_err_code),
      .key_prog_set   (key_prog_set),
      .key_erase_set  (key_erase_set),
      .rd_addr        (addr_reg),
      .rd_data        (cs_rd_data),
      .key_status     (key_status),
      .sys_reset_req  (sys_reset_req),
      .nvmprog_active (nvmprog_active)
   );

   assign tx_valid = (state_reg == TGT_RESP);
   assign tx_data  = tx_valid ? resp_byte : 8'h00;
   assign busy     = (state_reg != TGT_IDLE);

endmodule

// File: tb/tb_updi_target_responder.sv
// Self-checking bench for updi_target_responder against a transaction-level CS/key model.
`timescale 1ns/1ps
module tb_updi_target_responder;

   localparam int G = 12;
   localparam logic [127:0] TB_SIB = 128'hF00DCAFE0123456789ABCDEF5AA5C33C;
   localparam logic [63:0]  TB_PROG  = "NVMProg ";
   localparam logic [63:0]  TB_ERASE = "NVMErase";

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_valid = 1'b0, rx_break = 1'b0, tx_ready = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic [7:0] tx_data, key_status;
   logic       tx_valid, sys_reset_req, nvmprog_active, busy;

   int checks = 0;
   int errors = 0;
   logic [7:0] cs [16];

   updi_target_responder #(
      .GUARD_CYCLES(G), .UPDI_REV(4'h3)
`ifdef UPDI_TGT_SIB_EN
      , .SIB_WORD(TB_SIB)
`endif
   ) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_break(rx_break),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .key_status(key_status),
      .sys_reset_req(sys_reset_req), .nvmprog_active(nvmprog_active), .busy(busy)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic bit is_impl(input int a);
      return a inside {0, 1, 2, 3, 7, 8, 9, 10, 11, 12};
   endfunction

   function automatic bit is_ro(input int a);
      return a inside {0, 7, 11};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) cs[i] = 8'h00;
      cs[0]  = 8'h30;
      cs[11] = 8'h01;
   endtask

   task automatic model_stcs(input int a, input logic [7:0] d);
      if (!is_impl(a) || is_ro(a)) return;
      if (a == 8 && d == 8'h00 && cs[8] == 8'h59) begin
         if (cs[7][4]) begin cs[11][3] = 1'b1; cs[7][4] = 1'b0; end
         if (cs[7][3]) begin cs[7][3] = 1'b0; cs[11][0] = 1'b0; end
      end
      cs[a] = d;
   endtask

   task automatic model_key(input logic [63:0] k);
      if (k == TB_PROG) cs[7][4] = 1'b1;
      else if (k == TB_ERASE) cs[7][3] = 1'b1;
   endtask

   function automatic logic [7:0] model_read(input int a);
      return is_impl(a) ? cs[a] : 8'h00;
   endfunction

   // ---------------- drivers (all at negedge) ----------------
   task automatic send_byte(input logic [7:0] b);
      rx_data = b; rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic pulse_break();
      rx_break = 1'b1;
      @(negedge clk);
      rx_break = 1'b0;
   endtask

   task automatic send_key(input logic [63:0] k);
      send_byte(8'h55); send_byte(8'hE0);
      for (int i = 0; i < 8; i++) send_byte(k[i*8 +: 8]);
      $display("key  %h", k);
   endtask

   task automatic do_stcs(input int a, input logic [7:0] d);
      send_byte(8'h55); send_byte({4'hC, 4'(a)}); send_byte(d);
      model_stcs(a, d);
      $display("stcs addr=%h data=%h", a, d);
   endtask

   task automatic watch_no_tx(input int n, output bit seen);
      seen = 1'b0;
      repeat (n) begin
         @(negedge clk);
         if (tx_valid) seen = 1'b1;
      end
   endtask

   // Waits for the response (bounded), captures it, holds tx_ready low, then handshakes.
   task automatic do_ldcs(input int a, input int hold, output logic [7:0] data,
                          output int lat, output bit stable);
      send_byte(8'h55); send_byte({4'h8, 4'(a)});
      lat = 1;
      while (!tx_valid && lat < G + 20) begin @(negedge clk); lat++; end
      stable = 1'b1;
      data = tx_data;
      if (!tx_valid) begin lat = -1; return; end
      repeat (hold) begin
         @(negedge clk);
         if (tx_valid !== 1'b1 || tx_data !== data) stable = 1'b0;
      end
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      $display("ldcs addr=%h data=%h lat=%0d", a, data, lat);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [7:0] d; int lat; bit st;
      checks++;
      if ({tx_valid, tx_data, key_status, sys_reset_req, nvmprog_active, busy} !== 20'h0) begin
         errors++;
         $display("FAIL reset_outputs got tv=%b td=%h ks=%h srr=%b nvm=%b busy=%b required all 0",
                  tx_valid, tx_data, key_status, sys_reset_req, nvmprog_active, busy);
      end
      do_ldcs(0, 5, d, lat, st);
      checks++; if (d !== 8'h30) begin errors++; $display("FAIL statusa got %h required 30", d); end
      checks++; if (lat !== G) begin errors++; $display("FAIL guard_latency got %0d required %0d", lat, G); end
      checks++; if (!st) begin errors++; $display("FAIL hold_stable got unstable required stable"); end
      checks++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL idle_after_hs got busy=%b tv=%b required 0 0", busy, tx_valid); end
      do_ldcs(11, 0, d, lat, st);
      checks++; if (d !== 8'h01) begin errors++; $display("FAIL sys_status_reset got %h required 01", d); end
   endtask

   task automatic test_stcs_random();
      int addrs [11] = '{1, 2, 3, 9, 10, 12, 0, 7, 11, 13, 4};
      logic [7:0] d, wd; int lat, a; bit st;
      for (int n = 0; n < 14; n++) begin
         a  = addrs[$urandom_range(0, 10)];
         wd = 8'($urandom);
         do_stcs(a, wd);
         do_ldcs(a, $urandom_range(0, 3), d, lat, st);
         checks++;
         if (d !== model_read(a) || lat !== G || !st || busy !== 1'b0) begin
            errors++;
            $display("FAIL stcs_ldcs addr=%h got %h lat=%0d st=%b busy=%b required %h lat=%0d",
                     a, d, lat, st, busy, model_read(a), G);
         end
      end
   endtask

   task automatic test_key();
      logic [7:0] d; int lat; bit st; logic [63:0] bad;
      bad = {32'($urandom), 32'($urandom)};
      send_key(bad); model_key(bad);
      checks++; if (key_status !== cs[7]) begin errors++; $display("FAIL key_mismatch got %h required %h", key_status, cs[7]); end
      send_key(TB_PROG); model_key(TB_PROG);
      checks++; if (key_status !== cs[7] || busy !== 1'b0) begin errors++; $display("FAIL key_prog got %h busy=%b required %h busy=0", key_status, busy, cs[7]); end
      do_stcs(8, 8'h59);
      checks++; if (sys_reset_req !== 1'b1) begin errors++; $display("FAIL reset_req_set got %b required 1", sys_reset_req); end
      do_stcs(8, 8'h00);
      checks++;
      if (nvmprog_active !== cs[11][3] || key_status !== cs[7] || sys_reset_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got nvm=%b ks=%h srr=%b required nvm=%b ks=%h srr=0",
                  nvmprog_active, key_status, sys_reset_req, cs[11][3], cs[7]);
      end
      send_key(TB_ERASE); model_key(TB_ERASE);
      checks++; if (key_status !== cs[7]) begin errors++; $display("FAIL key_erase got %h required %h", key_status, cs[7]); end
      do_stcs(8, 8'h59); do_stcs(8, 8'h00);
      do_ldcs(11, 1, d, lat, st);
      checks++; if (d !== cs[11] || key_status !== cs[7]) begin errors++; $display("FAIL erase_release got ss=%h ks=%h required ss=%h ks=%h", d, key_status, cs[11], cs[7]); end
   endtask

   task automatic test_illegal();
      logic [7:0] d; int lat; bit st, seen;
      send_byte(8'h55); send_byte(8'hA5); cs[1][2:0] = 3'h4;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL illegal_busy got %b required 1", busy); end
      send_byte(8'h55); send_byte(8'h80);
      watch_no_tx(G + 4, seen);
      checks++; if (seen) begin errors++; $display("FAIL error_ignores got tx required none"); end
      // break and a sync byte in the same cycle: break wins
      rx_break = 1'b1; rx_valid = 1'b1; rx_data = 8'h55;
      @(negedge clk);
      rx_break = 1'b0; rx_valid = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_priority got busy=%b required 0", busy); end
      do_ldcs(1, 0, d, lat, st);
      checks++; if (d !== cs[1] || d[2:0] !== 3'h4) begin errors++; $display("FAIL statusb_illegal got %h required %h", d, cs[1]); end
   endtask

   task automatic test_e5();
      logic [7:0] d; int lat; bit st, seen;
`ifdef UPDI_TGT_SIB_EN
      logic [127:0] sib;
      sib = TB_SIB;
      send_byte(8'h55); send_byte(8'hE5);
      lat = 1;
      while (!tx_valid && lat < G + 20) begin @(negedge clk); lat++; end
      checks++; if (lat !== G) begin errors++; $display("FAIL sib_latency got %0d required %0d", lat, G); end
      for (int i = 0; i < 16; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         checks++;
         if (tx_valid !== 1'b1 || tx_data !== sib[i*8 +: 8]) begin
            errors++;
            $display("FAIL sib_byte%0d got tv=%b %h required %h", i, tx_valid, tx_data, sib[i*8 +: 8]);
         end
         $display("sib  idx=%0d data=%h", i, tx_data);
         tx_ready = 1'b1; @(negedge clk); tx_ready = 1'b0;
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sib_done got busy=%b required 0", busy); end
`else
      send_byte(8'h55); send_byte(8'hE5); cs[1][2:0] = 3'h4;
      watch_no_tx(G + 4, seen);
      checks++; if (seen || busy !== 1'b1) begin errors++; $display("FAIL e5_illegal got tx=%b busy=%b required tx=0 busy=1", seen, busy); end
      pulse_break();
      do_ldcs(1, 0, d, lat, st);
      checks++; if (d !== cs[1]) begin errors++; $display("FAIL e5_statusb got %h required %h", d, cs[1]); end
`endif
   endtask

   task automatic test_guard_error();
      logic [7:0] d; int lat; bit st, seen;
      send_byte(8'h55); send_byte(8'h80);
      repeat (2) @(negedge clk);
      send_byte(8'h11); cs[1][2:0] = 3'h1;
      watch_no_tx(G + 4, seen);
      checks++; if (seen || busy !== 1'b1) begin errors++; $display("FAIL guard_rx got tx=%b busy=%b required tx=0 busy=1", seen, busy); end
      pulse_break();
      do_ldcs(1, 0, d, lat, st);
      checks++; if (d !== cs[1]) begin errors++; $display("FAIL statusb_parity got %h required %h", d, cs[1]); end
   endtask

   task automatic test_break_resp();
      int n;
      send_byte(8'h55); send_byte(8'h80);
      n = 0;
      while (!tx_valid && n < G + 20) begin @(negedge clk); n++; end
      checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL resp_timeout got tv=%b required 1", tx_valid); end
      pulse_break();
      checks++;
      if (tx_valid !== 1'b0 || busy !== 1'b0 || nvmprog_active !== cs[11][3]) begin
         errors++;
         $display("FAIL break_resp got tv=%b busy=%b nvm=%b required 0 0 %b", tx_valid, busy, nvmprog_active, cs[11][3]);
      end
   endtask

   task automatic test_reset_mid_key();
      logic [7:0] d; int lat; bit st;
      send_byte(8'h55); send_byte(8'hE0);
      send_byte(8'h20); send_byte(8'h67); send_byte(8'h6F);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({tx_valid, tx_data, key_status, sys_reset_req, nvmprog_active, busy} !== 20'h0) begin
         errors++;
         $display("FAIL rst_mid_key got tv=%b td=%h ks=%h srr=%b nvm=%b busy=%b required all 0",
                  tx_valid, tx_data, key_status, sys_reset_req, nvmprog_active, busy);
      end
      rst = 1'b0; model_reset();
      @(negedge clk);
      do_ldcs(11, 0, d, lat, st);
      checks++; if (d !== cs[11]) begin errors++; $display("FAIL post_rst_sys got %h required %h", d, cs[11]); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d; int lat, a; bit st;
      do_stcs(2, 8'hA7); do_stcs(3, 8'h5C);
      for (int n = 0; n < 6; n++) begin
         a = $urandom_range(0, 15);
         do_ldcs(a, 0, d, lat, st);
         checks++;
         if (d !== model_read(a) || lat !== G) begin
            errors++;
            $display("FAIL b2b addr=%h got %h lat=%0d required %h lat=%0d", a, d, lat, model_read(a), G);
         end
      end
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_stcs_random();
      test_key();
      test_illegal();
      test_e5();
      test_guard_error();
      test_break_resp();
      test_reset_mid_key();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
